// File: rtl/md_pkg.sv
// md_pkg: shared op/state types and helpers for the multiply/divide sequencer.
package md_pkg;
  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
    MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU, MD_MUL
  } MdOpType;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} MdStateType;
  localparam int DIV_BITS_DEF = 1;
  localparam int DIV_CYCLES = 32 / DIV_BITS_DEF;
  function automatic logic is_div(MdOpType op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
  function automatic logic is_signed(MdOpType op);
    return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB, MD_MUL};
  endfunction
endpackage

// File: rtl/div_iter.sv
// div_iter: unsigned restoring divider, DIV_BITS quotient bits per cycle.
// o_quot/o_rem show the values after the current cycle's step, so o_done marks the final one.
module div_iter import md_pkg::*; #(
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem,
  output logic        o_done
);
  localparam int N = 32 / DIV_BITS;
  logic [31:0] r_quot, r_rem, r_div, w_q, w_r;
  logic [32:0] w_sh;
  logic [4:0]  r_cnt;
  logic        r_busy;
  always_comb begin
    w_q  = r_quot;
    w_r  = r_rem;
    w_sh = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      w_sh = {w_r, w_q[31]};
      w_q  = {w_q[30:0], 1'b0};
      if (w_sh >= {1'b0, r_div}) begin
        w_sh   = w_sh - {1'b0, r_div};
        w_q[0] = 1'b1;
      end
      w_r = w_sh[31:0];
    end
  end
  assign o_quot = w_q;
  assign o_rem  = w_r;
  assign o_done = r_busy && r_cnt == 5'(N - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_quot <= w_q;
      r_rem  <= w_r;
      r_cnt  <= r_cnt + 5'd1;
      r_busy <= !o_done;
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle mult/div sequencer in EXE, producing a one-shot HI/LO (or MUL rd) result.
module muldiv_ctrl import md_pkg::*; #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_MdOp,
  input  logic        EXE_MdValid,
  input  logic [31:0] EXE_SrcA,
  input  logic [31:0] EXE_SrcB,
  input  logic [31:0] EXE_HiIn,
  input  logic [31:0] EXE_LoIn,
  input  logic        Flush,
  input  logic        Stall_in,
  output logic        MD_Busy,
  output logic        MD_Valid,
  output logic        MD_HiLoWr,
  output logic [31:0] MD_Hi,
  output logic [31:0] MD_Lo
);
  MdStateType  r_state, w_next;
  MdOpType     r_op, w_op;
  logic [31:0] r_a, r_b, r_hi_in, r_lo_in, r_hi, r_lo;
  logic [31:0] w_mag_a, w_mag_b, w_quot, w_rem, w_quo_fix, w_rem_fix;
  logic [63:0] w_prod, w_acc, w_res;
  logic [2:0]  r_cnt;
  logic        w_start, w_mul_last, w_div_done, w_sa, w_ds;
  assign w_op       = MdOpType'(EXE_MdOp);
  assign w_start    = r_state == S_IDLE && EXE_MdValid && w_op != MD_NONE && !Flush;
  assign w_mul_last = r_state == S_MUL && r_cnt == 3'(MUL_LAT - 1);
  assign w_sa       = is_signed(r_op);
  assign w_prod     = {{32{w_sa & r_a[31]}}, r_a} * {{32{w_sa & r_b[31]}}, r_b};
  assign w_acc      = {r_hi_in, r_lo_in};
  assign w_res      = r_op inside {MD_MADD, MD_MADDU} ? w_acc + w_prod :
                      r_op inside {MD_MSUB, MD_MSUBU} ? w_acc - w_prod : w_prod;
  // The divider core sees magnitudes straight from EXE so it can load on the start edge.
  assign w_ds       = is_signed(w_op);
  assign w_mag_a    = w_ds && EXE_SrcA[31] ? -EXE_SrcA : EXE_SrcA;
  assign w_mag_b    = w_ds && EXE_SrcB[31] ? -EXE_SrcB : EXE_SrcB;
  assign w_quo_fix  = r_b == '0 ? '1 : w_sa && (r_a[31] ^ r_b[31]) ? -w_quot : w_quot;
  assign w_rem_fix  = r_b == '0 ? r_a : w_sa && r_a[31] ? -w_rem : w_rem;
  div_iter #(.DIV_BITS(DIV_BITS)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start && is_div(w_op)),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_done     (w_div_done)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = Flush ? S_IDLE :
             r_state == S_IDLE ? (w_start ? (is_div(w_op) ? S_DIV : S_MUL) : S_IDLE) :
             r_state == S_MUL  ? (w_mul_last ? S_DONE : S_MUL) :
             r_state == S_DIV  ? (w_div_done ? S_DONE : S_DIV) :
             (Stall_in ? S_DONE : S_IDLE);
  end
  always_comb begin
    MD_Busy   = !Flush && (w_start || r_state == S_MUL || r_state == S_DIV);
    MD_Valid  = !Flush && r_state == S_DONE;
    MD_HiLoWr = MD_Valid && r_op != MD_MUL;
    MD_Hi     = r_hi;
    MD_Lo     = r_lo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= MD_NONE;
      r_a     <= '0;
      r_b     <= '0;
      r_hi_in <= '0;
      r_lo_in <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_start) begin
        r_op    <= w_op;
        r_a     <= EXE_SrcA;
        r_b     <= EXE_SrcB;
        r_hi_in <= EXE_HiIn;
        r_lo_in <= EXE_LoIn;
        r_cnt   <= '0;
      end else if (r_state == S_MUL) r_cnt <= r_cnt + 3'd1;
      if (!Flush && w_mul_last) {r_hi, r_lo} <= w_res;
      if (!Flush && r_state == S_DIV && w_div_done) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors with hand-computed results for the mult/div sequencer.
module tb_muldiv_ctrl;
  import md_pkg::*;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = DIV_CYCLES;
  logic        clk = 0, rst = 1;
  logic [3:0]  EXE_MdOp = MD_NONE;
  logic        EXE_MdValid = 0, Flush = 0, Stall_in = 0;
  logic [31:0] EXE_SrcA = 0, EXE_SrcB = 0, EXE_HiIn = 0, EXE_LoIn = 0;
  logic        MD_Busy, MD_Valid, MD_HiLoWr;
  logic [31:0] MD_Hi, MD_Lo;
  int total = 0, bad = 0;
  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_BITS(DIV_BITS_DEF)) dut (
    .clk(clk), .rst(rst), .EXE_MdOp(EXE_MdOp), .EXE_MdValid(EXE_MdValid),
    .EXE_SrcA(EXE_SrcA), .EXE_SrcB(EXE_SrcB), .EXE_HiIn(EXE_HiIn), .EXE_LoIn(EXE_LoIn),
    .Flush(Flush), .Stall_in(Stall_in), .MD_Busy(MD_Busy), .MD_Valid(MD_Valid),
    .MD_HiLoWr(MD_HiLoWr), .MD_Hi(MD_Hi), .MD_Lo(MD_Lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
    EXE_MdOp = op;
    EXE_MdValid = 1;
    EXE_SrcA = a;
    EXE_SrcB = b;
    EXE_HiIn = hi;
    EXE_LoIn = lo;
  endtask
  task automatic idle_in();
    EXE_MdValid = 0;
    EXE_MdOp = MD_NONE;
  endtask
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, b, hi, lo,
                        input logic [31:0] ehi, elo, input logic ewr, chk_hi, input int lat, nstall);
    int n, vcnt;
    logic busy_ok, hold_ok;
    @(negedge clk);
    drive(op, a, b, hi, lo);
    #1 check({tag, "_busy_start"}, MD_Busy, 1);
    @(posedge clk); #1;
    idle_in();
    n = 1;
    busy_ok = 1;
    while (!MD_Valid && n < 100) begin
      busy_ok &= MD_Busy;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, lat + 1);
    check({tag, "_busy_run"}, busy_ok, 1);
    check({tag, "_busy_done"}, MD_Busy, 0);
    check({tag, "_lo"}, MD_Lo, elo);
    if (chk_hi) check({tag, "_hi"}, MD_Hi, ehi);
    check({tag, "_hilowr"}, MD_HiLoWr, ewr);
    vcnt = 0;
    hold_ok = 1;
    while (MD_Valid && vcnt < 20) begin
      vcnt++;
      hold_ok &= MD_Lo === elo && (!chk_hi || MD_Hi === ehi) && MD_HiLoWr === ewr;
      Stall_in = vcnt <= nstall;
      @(posedge clk); #1;
    end
    Stall_in = 0;
    check({tag, "_valid_cycles"}, vcnt, nstall + 1);
    check({tag, "_hold"}, hold_ok, 1);
    check({tag, "_idle_busy"}, MD_Busy, 0);
  endtask
  initial begin
    int n;
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", MD_Busy, 0);
    check("rst_valid", MD_Valid, 0);
    check("rst_hilowr", MD_HiLoWr, 0);
    check("rst_hi", MD_Hi, 0);
    check("rst_lo", MD_Lo, 0);
    @(negedge clk) rst = 0;
    run_op("mult",    MD_MULT,  32'hFFFFFFFF, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 1, MUL_LAT, 0);
    run_op("div_neg", MD_DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 1, DIV_LAT, 0);
    run_op("divu_z",  MD_DIVU,  32'd7, 32'd0, 0, 0, 32'd7, 32'hFFFFFFFF, 1, 1, DIV_LAT, 0);
    run_op("div_ovf", MD_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 32'd0, 32'h80000000, 1, 1, DIV_LAT, 0);
    run_op("div_z",   MD_DIV,   32'hFFFFFFFB, 32'd0, 0, 0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, 1, DIV_LAT, 0);
    run_op("div_mix", MD_DIV,   32'd7, 32'hFFFFFFFE, 0, 0, 32'd1, 32'hFFFFFFFD, 1, 1, DIV_LAT, 0);
    run_op("multu",   MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'd1, 1, 1, MUL_LAT, 0);
    run_op("madd",    MD_MADD,  32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 1, MUL_LAT, 0);
    run_op("msubu",   MD_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, MUL_LAT, 0);
    run_op("msub",    MD_MSUB,  32'hFFFFFFFD, 32'd4, 32'd0, 32'd10, 32'd0, 32'h16, 1, 1, MUL_LAT, 0);
    run_op("maddu",   MD_MADDU, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFE, 1, 1, MUL_LAT, 0);
    run_op("mul",     MD_MUL,   32'd3, 32'hFFFFFFFC, 0, 0, 32'd0, 32'hFFFFFFF4, 0, 0, MUL_LAT, 0);
    run_op("stall",   MD_DIVU,  32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 1, 1, DIV_LAT, 3);
    // Flush in the middle of a divide, then a clean multiply.
    @(negedge clk);
    drive(MD_DIV, 32'd100, 32'd3, 0, 0);
    @(posedge clk); #1;
    idle_in();
    repeat (9) @(posedge clk);
    @(negedge clk) Flush = 1;
    #1 check("flush_busy", MD_Busy, 0);
    check("flush_valid", MD_Valid, 0);
    @(posedge clk); #1;
    Flush = 0;
    check("flush_idle_busy", MD_Busy, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= MD_Valid;
    end
    check("flush_no_valid", seen, 0);
    run_op("mult_after_flush", MD_MULT, 32'd5, 32'd6, 0, 0, 32'd0, 32'd30, 1, 1, MUL_LAT, 0);
    // Flush coinciding with a start suppresses it.
    @(negedge clk);
    drive(MD_MULT, 32'd2, 32'd3, 0, 0);
    Flush = 1;
    #1 check("flush_start_busy", MD_Busy, 0);
    @(posedge clk); #1;
    idle_in();
    Flush = 0;
    check("flush_start_nostart", MD_Busy, 0);
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      seen |= MD_Valid;
    end
    check("flush_start_no_valid", seen, 0);
    // Back-to-back: the MULT waiting in EXE must not start while S_DONE is showing.
    @(negedge clk);
    drive(MD_DIV, 32'd20, 32'd6, 0, 0);
    @(posedge clk); #1;
    idle_in();
    n = 0;
    while (!MD_Valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_div_lo", MD_Lo, 3);
    check("b2b_div_hi", MD_Hi, 2);
    drive(MD_MULT, 32'd7, 32'd8, 0, 0);
    #1 check("b2b_no_start_in_done", MD_Busy, 0);
    @(posedge clk); #1;
    check("b2b_start_busy", MD_Busy, 1);
    check("b2b_start_valid", MD_Valid, 0);
    @(posedge clk); #1;
    idle_in();
    n = 0;
    while (!MD_Valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_mult_latency", n, MUL_LAT);
    check("b2b_mult_lo", MD_Lo, 56);
    check("b2b_mult_hi", MD_Hi, 0);
    @(posedge clk); #1;
    check("b2b_end_valid", MD_Valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
